// File: rtl/bus_gate_arbiter_if.sv
// Gated-source bus bundle: per-source requests and words in, the arbitrated bus and error status out.
interface bus_gate_arbiter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_SRC = 4
);
  localparam int unsigned SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]       gate;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic                   err_clear;
  logic [WIDTH-1:0]       data_out;
  logic                   bus_valid;
  logic [SEL_W-1:0]       src_sel;
  logic                   contention;
  logic                   err_sticky;
  logic [7:0]             err_count;

  // Sources and error control drive the arbiter; the arbiter drives the bus and status.
  modport master (
    output gate, src_data, err_clear,
    input  data_out, bus_valid, src_sel, contention, err_sticky, err_count
  );

  modport slave (
    input  gate, src_data, err_clear,
    output data_out, bus_valid, src_sel, contention, err_sticky, err_count
  );
endinterface

// File: rtl/bus_gate_arbiter.sv
// Registered arbiter for N gated sources onto one bus, with contention detection,
// a sticky error flag and a saturating contention counter.
module bus_gate_arbiter #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned PRIO_MODE = 0
) (
  input logic               clk,
  input logic               reset,
  bus_gate_arbiter_if.slave bus
);
  localparam int unsigned SEL_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [7:0]  COUNT_MAX = 8'hFF;

  logic [SEL_W-1:0] first_idx;
  logic [WIDTH-1:0] first_word;
  logic             any_gate;
  logic             multi_gate;
  logic             load;

  // Lowest-index requester and its word; contention is two or more request bits set.
  always_comb begin
    first_idx  = '0;
    first_word = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus.gate[i]) begin
        first_idx  = SEL_W'(i);
        first_word = bus.src_data[i*WIDTH +: WIDTH];
      end
    end
    any_gate   = |bus.gate;
    multi_gate = |(bus.gate & (bus.gate - N_SRC'(1)));
    load       = any_gate && (!multi_gate || (PRIO_MODE == 0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_out   <= '0;
      bus.src_sel    <= '0;
      bus.bus_valid  <= 1'b0;
      bus.contention <= 1'b0;
      bus.err_sticky <= 1'b0;
      bus.err_count  <= '0;
    end else begin
      bus.bus_valid  <= load;
      bus.contention <= multi_gate;
      if (load) begin
        bus.data_out <= first_word;
        bus.src_sel  <= first_idx;
      end
      // A contention cycle outranks a simultaneous clear for both the flag and the count.
      if (multi_gate) begin
        bus.err_sticky <= 1'b1;
      end else if (bus.err_clear) begin
        bus.err_sticky <= 1'b0;
      end
      if (bus.err_clear) begin
        bus.err_count <= multi_gate ? 8'd1 : 8'd0;
      end else if (multi_gate && (bus.err_count != COUNT_MAX)) begin
        bus.err_count <= bus.err_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed bench: one arbiter per contention policy, fed identical stimulus, checked against hand-computed values.
module tb_bus_gate_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  gate;
  logic [63:0] src_data;
  logic        err_clear;

  int checks = 0;
  int errors = 0;

  bus_gate_arbiter_if #(.WIDTH(16), .N_SRC(4)) if0 ();
  bus_gate_arbiter_if #(.WIDTH(16), .N_SRC(4)) if1 ();

  assign if0.gate      = gate;
  assign if0.src_data  = src_data;
  assign if0.err_clear = err_clear;
  assign if1.gate      = gate;
  assign if1.src_data  = src_data;
  assign if1.err_clear = err_clear;

  bus_gate_arbiter #(.WIDTH(16), .N_SRC(4), .PRIO_MODE(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  bus_gate_arbiter #(.WIDTH(16), .N_SRC(4), .PRIO_MODE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int idx, input logic [15:0] v);
    src_data[idx*16 +: 16] = v;
  endtask

  initial begin
    gate      = 4'b0001;
    src_data  = '0;
    err_clear = 1'b1;
    reset     = 1'b1;
    set_slice(0, 16'hABCD);
    #2;

    // Reset dominates gate and clear
    step();
    check("rst_data0",   32'(if0.data_out),   32'h0);
    check("rst_sel0",    32'(if0.src_sel),    32'h0);
    check("rst_valid0",  32'(if0.bus_valid),  32'h0);
    check("rst_cont0",   32'(if0.contention), 32'h0);
    check("rst_sticky0", 32'(if0.err_sticky), 32'h0);
    check("rst_count0",  32'(if0.err_count),  32'h0);
    check("rst_data1",   32'(if1.data_out),   32'h0);

    reset     = 1'b0;
    err_clear = 1'b0;
    step();
    check("post_rst_data", 32'(if0.data_out),  32'hABCD);
    check("post_rst_valid", 32'(if0.bus_valid), 32'h1);
    check("post_rst_sel",  32'(if0.src_sel),   32'h0);

    // Tracking a held single gate
    for (int k = 1; k <= 3; k++) begin
      set_slice(0, 16'(k));
      step();
      check("track_data0", 32'(if0.data_out), 32'(k));
      check("track_data1", 32'(if1.data_out), 32'(k));
    end

    // Single-source transfer then idle
    gate = 4'b0100;
    set_slice(2, 16'hBEEF);
    step();
    check("single_data0",  32'(if0.data_out),   32'hBEEF);
    check("single_sel0",   32'(if0.src_sel),    32'h2);
    check("single_valid0", 32'(if0.bus_valid),  32'h1);
    check("single_cont0",  32'(if0.contention), 32'h0);
    check("single_data1",  32'(if1.data_out),   32'hBEEF);
    gate = 4'b0000;
    step();
    check("idle_data0",  32'(if0.data_out),   32'hBEEF);
    check("idle_valid0", 32'(if0.bus_valid),  32'h0);
    check("idle_sel0",   32'(if0.src_sel),    32'h2);
    check("idle_cont0",  32'(if0.contention), 32'h0);

    // Contention 1010
    gate = 4'b1010;
    set_slice(1, 16'h1111);
    set_slice(3, 16'h3333);
    step();
    check("c1_data0",   32'(if0.data_out),   32'h1111);
    check("c1_sel0",    32'(if0.src_sel),    32'h1);
    check("c1_valid0",  32'(if0.bus_valid),  32'h1);
    check("c1_cont0",   32'(if0.contention), 32'h1);
    check("c1_sticky0", 32'(if0.err_sticky), 32'h1);
    check("c1_count0",  32'(if0.err_count),  32'h1);
    check("c1_data1",   32'(if1.data_out),   32'hBEEF);
    check("c1_sel1",    32'(if1.src_sel),    32'h2);
    check("c1_valid1",  32'(if1.bus_valid),  32'h0);
    check("c1_cont1",   32'(if1.contention), 32'h1);

    // Contention 1111: slice0 still holds 3
    gate = 4'b1111;
    step();
    check("c2_data0",  32'(if0.data_out),   32'h0003);
    check("c2_sel0",   32'(if0.src_sel),    32'h0);
    check("c2_cont0",  32'(if0.contention), 32'h1);
    check("c2_count0", 32'(if0.err_count),  32'h2);
    check("c2_data1",  32'(if1.data_out),   32'hBEEF);
    check("c2_valid1", 32'(if1.bus_valid),  32'h0);
    check("c2_cont1",  32'(if1.contention), 32'h1);
    check("c2_count1", 32'(if1.err_count),  32'h2);

    gate      = 4'b0000;
    err_clear = 1'b1;
    step();
    check("clr_sticky0", 32'(if0.err_sticky), 32'h0);
    check("clr_count0",  32'(if0.err_count),  32'h0);
    check("clr_cont0",   32'(if0.contention), 32'h0);
    err_clear = 1'b0;

    // 300 back-to-back contention cycles
    gate = 4'b0011;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 1 || k == 2 || k == 300) check("sat_pulse", 32'(if0.contention), 32'h1);
      if (k == 255) check("sat_count255", 32'(if0.err_count), 32'd255);
    end
    check("sat_count0", 32'(if0.err_count), 32'd255);
    check("sat_count1", 32'(if1.err_count), 32'd255);

    err_clear = 1'b1;
    step();
    check("clr_cont_count",  32'(if0.err_count),  32'd1);
    check("clr_cont_sticky", 32'(if0.err_sticky), 32'h1);
    gate = 4'b0000;
    step();
    check("clr2_count",  32'(if0.err_count),  32'd0);
    check("clr2_sticky", 32'(if0.err_sticky), 32'h0);
    err_clear = 1'b0;

    // Reset mid-transfer, then normal evaluation
    gate  = 4'b0100;
    set_slice(2, 16'h5A5A);
    reset = 1'b1;
    step();
    check("mid_rst_data",  32'(if0.data_out),  32'h0);
    check("mid_rst_valid", 32'(if0.bus_valid), 32'h0);
    reset = 1'b0;
    step();
    check("after_rst_data",  32'(if0.data_out),  32'h5A5A);
    check("after_rst_sel",   32'(if0.src_sel),   32'h2);
    check("after_rst_valid", 32'(if0.bus_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
